// File: rtl/riscv_multicycle_ctrl_if.sv
// rtl/riscv_multicycle_ctrl_if.sv - instruction/flag/memory handshake bundle between multicycle controller and datapath
interface riscv_multicycle_ctrl_if #(
    parameter int ALUCTRL_W = 4
);
    // Datapath and memory to controller
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 Neg;
    logic                 Ovf;
    logic                 Carry;
    logic                 mem_ready;

    // Controller to datapath and memory
    logic                 mem_req;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 trap;

    modport master (
        input  op, funct3, funct7b5, Zero, Neg, Ovf, Carry, mem_ready,
        output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Neg, Ovf, Carry, mem_ready,
        input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - multicycle RV32I control FSM with memory wait/timeout and trap; optional RISCV_MC_PERF_CNT_EN counters
module riscv_multicycle_ctrl #(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 0
`ifdef RISCV_MC_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    riscv_multicycle_ctrl_if.master   bus
`ifdef RISCV_MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          instret_cnt
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALRADR  = 4'd11;
    localparam logic [3:0] S_JALRJMP  = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_AUIPC    = 4'd14;
    localparam logic [3:0] S_ERROR    = 4'd15;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    // Wait counter only needs to reach MEM_TIMEOUT; one bit when timeout is disabled.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              w_timeout;
    logic              w_taken;
    logic [3:0]        w_alu_dec;

    logic              w_mem_req;
    logic              w_adr;
    logic              w_mw;
    logic              w_irw;
    logic              w_pcw;
    logic              w_rw;
    logic [1:0]        w_rs;
    logic [1:0]        w_a;
    logic [1:0]        w_b;
    logic [2:0]        w_imm;
    logic [3:0]        w_alu;
    logic              w_trap;

    assign w_wait_inc = r_wait + 1'b1;

    // Timeout fires on the cycle the count would reach the limit; a ready on that cycle takes priority.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_mem_req && !bus.mem_ready &&
                       (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

    // Branch condition from ALU flags of rs1 - rs2.
    always_comb begin
        case (bus.funct3)
            3'b000:  w_taken = bus.Zero;
            3'b001:  w_taken = ~bus.Zero;
            3'b100:  w_taken = bus.Neg ^ bus.Ovf;
            3'b101:  w_taken = ~(bus.Neg ^ bus.Ovf);
            3'b110:  w_taken = ~bus.Carry;
            3'b111:  w_taken = bus.Carry;
            default: w_taken = 1'b0;
        endcase
    end

    // ALU operation for register and immediate arithmetic; subtract only exists for R-type.
    always_comb begin
        case (bus.funct3)
            3'b000:  w_alu_dec = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_dec = ALU_SLL;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b011:  w_alu_dec = ALU_SLTU;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b101:  w_alu_dec = bus.funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_dec = ALU_OR;
            default: w_alu_dec = ALU_AND;
        endcase
    end

    // Next-state sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)  w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DECODE: begin
                case (bus.op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALRADR;
                    7'b0110111:             w_next = S_LUI;
                    7'b0010111:             w_next = S_AUIPC;
                    default:                w_next = S_ERROR;
                endcase
            end
            S_MEMADR:   w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (bus.mem_ready)  w_next = S_MEMWB;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready)  w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_EXECR, S_EXECI, S_JAL, S_JALRJMP, S_LUI, S_AUIPC: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = (bus.funct3[2:1] == 2'b01) ? S_ERROR : S_FETCH;
            S_JALRADR:  w_next = S_JALRJMP;
            default:    w_next = S_ERROR;
        endcase
    end

    // State register; ERROR is only left through reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Memory wait counter, restarted whenever the FSM moves to a new state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         r_wait <= '0;
        else if (w_next != r_state)         r_wait <= '0;
        else if (w_mem_req && !bus.mem_ready) r_wait <= w_wait_inc;
    end

    // Moore control decode; only the PC/IR strobes look at mem_ready or branch flags.
    always_comb begin
        w_mem_req = 1'b0;
        w_adr     = 1'b0;
        w_mw      = 1'b0;
        w_irw     = 1'b0;
        w_pcw     = 1'b0;
        w_rw      = 1'b0;
        w_rs      = 2'b00;
        w_a       = 2'b00;
        w_b       = 2'b00;
        w_imm     = IMM_I;
        w_alu     = ALU_ADD;
        w_trap    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_b       = 2'b10;
                w_rs      = 2'b10;
                w_irw     = bus.mem_ready;
                w_pcw     = bus.mem_ready;
            end
            S_DECODE: begin
                w_a   = 2'b01;
                w_b   = 2'b01;
                w_imm = IMM_B;
            end
            S_MEMADR: begin
                w_a   = 2'b10;
                w_b   = 2'b01;
                w_imm = bus.op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr     = 1'b1;
            end
            S_MEMWB: begin
                w_rs = 2'b01;
                w_rw = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req = 1'b1;
                w_adr     = 1'b1;
                w_mw      = 1'b1;
            end
            S_EXECR: begin
                w_a   = 2'b10;
                w_alu = w_alu_dec;
            end
            S_EXECI: begin
                w_a   = 2'b10;
                w_b   = 2'b01;
                w_alu = w_alu_dec;
            end
            S_ALUWB: w_rw = 1'b1;
            S_BRANCH: begin
                w_a   = 2'b10;
                w_alu = ALU_SUB;
                w_pcw = w_taken;
            end
            S_JAL, S_JALRJMP: begin
                w_a   = 2'b01;
                w_b   = 2'b10;
                w_pcw = 1'b1;
            end
            S_JALRADR: begin
                w_a = 2'b10;
                w_b = 2'b01;
            end
            S_LUI: begin
                w_a   = 2'b11;
                w_b   = 2'b01;
                w_imm = IMM_U;
            end
            S_AUIPC: begin
                w_a   = 2'b01;
                w_b   = 2'b01;
                w_imm = IMM_U;
            end
            S_ERROR: w_trap = 1'b1;
            default: w_trap = 1'b1;
        endcase
    end

    // Outputs forced low while reset is held so strobes drop without waiting for a clock.
    assign bus.mem_req    = reset & w_mem_req;
    assign bus.AdrSrc     = reset & w_adr;
    assign bus.MemWrite   = reset & w_mw;
    assign bus.IRWrite    = reset & w_irw;
    assign bus.PCWrite    = reset & w_pcw;
    assign bus.RegWrite   = reset & w_rw;
    assign bus.ResultSrc  = reset ? w_rs  : 2'b00;
    assign bus.ALUSrcA    = reset ? w_a   : 2'b00;
    assign bus.ALUSrcB    = reset ? w_b   : 2'b00;
    assign bus.ImmSrc     = reset ? w_imm : 3'b000;
    assign bus.ALUControl = reset ? ALUCTRL_W'(w_alu) : '0;
    assign bus.trap       = reset & w_trap;

`ifdef RISCV_MC_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

    // Cycle and retired-instruction counters; both stop once the core has trapped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else if (r_state != S_ERROR) begin
            r_cycle <= r_cycle + 1'b1;
            if (w_retire) r_instret <= r_instret + 1'b1;
        end
    end

    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb/tb_riscv_multicycle_ctrl.sv - scoreboard bench for riscv_multicycle_ctrl
`timescale 1ns/1ps
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zf, nf, vf, cf, mem_ready;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl_if #(.ALUCTRL_W(4)) bus_a ();
    riscv_multicycle_ctrl_if #(.ALUCTRL_W(4)) bus_b ();

    assign bus_a.op = op;             assign bus_b.op = op;
    assign bus_a.funct3 = funct3;     assign bus_b.funct3 = funct3;
    assign bus_a.funct7b5 = funct7b5; assign bus_b.funct7b5 = funct7b5;
    assign bus_a.Zero = zf;           assign bus_b.Zero = zf;
    assign bus_a.Neg = nf;            assign bus_b.Neg = nf;
    assign bus_a.Ovf = vf;            assign bus_b.Ovf = vf;
    assign bus_a.Carry = cf;          assign bus_b.Carry = cf;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.mem_ready = mem_ready;

`ifdef RISCV_MC_PERF_CNT_EN
    logic [3:0] cyc_a, ret_a, cyc_b, ret_b;
`endif

    riscv_multicycle_ctrl #(.ALUCTRL_W(4), .MEM_TIMEOUT(0)
`ifdef RISCV_MC_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a)
`ifdef RISCV_MC_PERF_CNT_EN
        , .cycle_cnt(cyc_a), .instret_cnt(ret_a)
`endif
    );

    riscv_multicycle_ctrl #(.ALUCTRL_W(4), .MEM_TIMEOUT(2)
`ifdef RISCV_MC_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b)
`ifdef RISCV_MC_PERF_CNT_EN
        , .cycle_cnt(cyc_b), .instret_cnt(ret_b)
`endif
    );

    typedef struct {
        logic        sel;
        logic        rstn;
        logic        rdy;
        logic [19:0] exp;
        string       tag;
    } ent_t;

    ent_t sb[$];

    // {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap}
    function automatic logic [19:0] v(input logic mreq, adr, mw, irw, pcw, rw,
                                      input logic [1:0] rs, a, b, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic trp);
        return {mreq, adr, mw, irw, pcw, rw, rs, a, b, imm, alu, trp};
    endfunction

    function automatic logic [19:0] obs(input logic sel);
        if (sel)
            return {bus_b.mem_req, bus_b.AdrSrc, bus_b.MemWrite, bus_b.IRWrite, bus_b.PCWrite,
                    bus_b.RegWrite, bus_b.ResultSrc, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ImmSrc,
                    bus_b.ALUControl, bus_b.trap};
        return {bus_a.mem_req, bus_a.AdrSrc, bus_a.MemWrite, bus_a.IRWrite, bus_a.PCWrite,
                bus_a.RegWrite, bus_a.ResultSrc, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ImmSrc,
                bus_a.ALUControl, bus_a.trap};
    endfunction

    function automatic logic [19:0] e_fetch(input logic rdy);
        return v(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0, 0);
    endfunction
    function automatic logic [19:0] e_decode();
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 4'h0, 0);
    endfunction
    function automatic logic [19:0] e_execr(input logic [3:0] alu);
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0);
    endfunction
    function automatic logic [19:0] e_execi(input logic [3:0] alu);
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0);
    endfunction
    function automatic logic [19:0] e_aluwb();
        return v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0, 0);
    endfunction
    function automatic logic [19:0] e_memadr(input logic st);
        return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, {2'b00, st}, 4'h0, 0);
    endfunction
    function automatic logic [19:0] e_branch(input logic tk);
        return v(0, 0, 0, 0, tk, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h1, 0);
    endfunction
    function automatic logic [19:0] e_upper(input logic [1:0] a);
        return v(0, 0, 0, 0, 0, 0, 2'b00, a, 2'b01, 3'b100, 4'h0, 0);
    endfunction

    localparam logic [19:0] E_MEMRD = 20'b1_1_0_0_0_0_00_00_00_000_0000_0;
    localparam logic [19:0] E_MEMWB = 20'b0_0_0_0_0_1_01_00_00_000_0000_0;
    localparam logic [19:0] E_MEMWR = 20'b1_1_1_0_0_0_00_00_00_000_0000_0;
    localparam logic [19:0] E_JMP   = 20'b0_0_0_0_1_0_00_01_10_000_0000_0;
    localparam logic [19:0] E_JRADR = 20'b0_0_0_0_0_0_00_10_01_000_0000_0;
    localparam logic [19:0] E_ERROR = 20'b0_0_0_0_0_0_00_00_00_000_0000_1;

    task automatic push(input logic sel, rstn, rdy, input logic [19:0] exp, input string tag);
        ent_t e;
        e.sel = sel; e.rstn = rstn; e.rdy = rdy; e.exp = exp; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic push_front_end(input logic sel, input int waits, input string tag);
        for (int i = 0; i < waits; i++) push(sel, 1, 0, e_fetch(0), {tag, "_fetch_wait"});
        push(sel, 1, 1, e_fetch(1), {tag, "_fetch"});
        push(sel, 1, 0, e_decode(), {tag, "_decode"});
    endtask

    // Applies each queued cycle just after the rising edge and checks on the falling edge.
    task automatic drain();
        ent_t        e;
        logic [19:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            reset     = e.rstn;
            mem_ready = e.rdy;
            @(negedge clk);
            got = obs(e.sel);
            total++;
            if (got !== e.exp) begin
                bad++;
                $display("FAIL %s: got %05h want %05h", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic test_reset();
        push(0, 0, 0, 20'h0, "reset_a");
        push(1, 0, 1, 20'h0, "reset_b_ready");
        drain();
    endtask

    task automatic test_alu();
        instr(7'b0110011, 3'b000, 1'b0);
        push_front_end(0, 0, "add");
        push(0, 1, 0, e_execr(4'h0), "add_execr");
        push(0, 1, 0, e_aluwb(), "add_aluwb");
        drain();
        instr(7'b0110011, 3'b000, 1'b1);
        push_front_end(0, 0, "sub");
        push(0, 1, 0, e_execr(4'h1), "sub_execr");
        push(0, 1, 0, e_aluwb(), "sub_aluwb");
        drain();
        instr(7'b0110011, 3'b011, 1'b0);
        push_front_end(0, 0, "sltu");
        push(0, 1, 0, e_execr(4'h9), "sltu_execr");
        push(0, 1, 0, e_aluwb(), "sltu_aluwb");
        drain();
        instr(7'b0010011, 3'b000, 1'b1);
        push_front_end(0, 0, "addi_f7");
        push(0, 1, 0, e_execi(4'h0), "addi_f7_execi");
        push(0, 1, 0, e_aluwb(), "addi_f7_aluwb");
        drain();
        instr(7'b0010011, 3'b101, 1'b1);
        push_front_end(0, 0, "srai");
        push(0, 1, 0, e_execi(4'h7), "srai_execi");
        push(0, 1, 0, e_aluwb(), "srai_aluwb");
        drain();
        instr(7'b0010011, 3'b001, 1'b0);
        push_front_end(0, 0, "slli");
        push(0, 1, 0, e_execi(4'h8), "slli_execi");
        push(0, 1, 0, e_aluwb(), "slli_aluwb");
        drain();
    endtask

    task automatic test_load();
        instr(7'b0000011, 3'b010, 1'b0);
        push_front_end(0, 1, "lw");
        push(0, 1, 0, e_memadr(0), "lw_memadr");
        for (int i = 0; i < 3; i++) push(0, 1, 0, E_MEMRD, "lw_memread_wait");
        push(0, 1, 1, E_MEMRD, "lw_memread_done");
        push(0, 1, 0, E_MEMWB, "lw_memwb");
        push(0, 1, 0, e_fetch(0), "lw_next_fetch");
        drain();
    endtask

    task automatic test_branch();
        instr(7'b1100011, 3'b101, 1'b0);
        nf = 1; vf = 1;
        push_front_end(0, 0, "bge_tk");
        push(0, 1, 0, e_branch(1), "bge_taken");
        drain();
        nf = 1; vf = 0;
        push_front_end(0, 0, "bge_nt");
        push(0, 1, 0, e_branch(0), "bge_not_taken");
        push(0, 1, 0, e_fetch(0), "bge_next_fetch");
        drain();
        instr(7'b1100011, 3'b110, 1'b0);
        cf = 0;
        push_front_end(0, 0, "bltu");
        push(0, 1, 0, e_branch(1), "bltu_taken");
        push(0, 1, 0, e_fetch(0), "bltu_next_fetch");
        drain();
        nf = 0; vf = 0; cf = 0;
    endtask

    task automatic test_jump_upper();
        instr(7'b1101111, 3'b000, 1'b0);
        push_front_end(0, 0, "jal");
        push(0, 1, 0, E_JMP, "jal_jal");
        push(0, 1, 0, e_aluwb(), "jal_aluwb");
        drain();
        instr(7'b1100111, 3'b000, 1'b0);
        push_front_end(0, 0, "jalr");
        push(0, 1, 0, E_JRADR, "jalr_adr");
        push(0, 1, 0, E_JMP, "jalr_jmp");
        push(0, 1, 0, e_aluwb(), "jalr_aluwb");
        drain();
        instr(7'b0110111, 3'b000, 1'b0);
        push_front_end(0, 0, "lui");
        push(0, 1, 0, e_upper(2'b11), "lui_lui");
        push(0, 1, 0, e_aluwb(), "lui_aluwb");
        drain();
        instr(7'b0010111, 3'b000, 1'b0);
        push_front_end(0, 0, "auipc");
        push(0, 1, 0, e_upper(2'b01), "auipc_auipc");
        push(0, 1, 0, e_aluwb(), "auipc_aluwb");
        drain();
    endtask

    task automatic test_illegal();
        instr(7'b1111111, 3'b000, 1'b0);
        push_front_end(0, 0, "ill");
        for (int i = 0; i < 3; i++) push(0, 1, 1, E_ERROR, "ill_error_hold");
        push(0, 0, 0, 20'h0, "ill_reset");
        push(0, 1, 0, e_fetch(0), "ill_after_reset");
        drain();
        instr(7'b1100011, 3'b011, 1'b0);
        push_front_end(0, 0, "bf3");
        push(0, 1, 0, e_branch(0), "bf3_branch");
        push(0, 1, 1, E_ERROR, "bf3_error");
        push(0, 0, 0, 20'h0, "bf3_reset");
        drain();
    endtask

    task automatic test_timeout();
        instr(7'b0100011, 3'b010, 1'b0);
        push(1, 0, 0, 20'h0, "to_reset");
        push_front_end(1, 0, "to_sw");
        push(1, 1, 0, e_memadr(1), "to_sw_memadr");
        push(1, 1, 0, E_MEMWR, "to_sw_memwrite1");
        push(1, 1, 0, E_MEMWR, "to_sw_memwrite2");
        push(1, 1, 0, E_ERROR, "to_sw_error");
        push(1, 1, 1, E_ERROR, "to_sw_error_hold");
        push(1, 0, 0, 20'h0, "to_reset2");
        push_front_end(1, 0, "rw_sw");
        push(1, 1, 0, e_memadr(1), "rw_memadr");
        push(1, 1, 0, E_MEMWR, "rw_memwrite_wait");
        push(1, 1, 1, E_MEMWR, "rw_memwrite_ready_at_limit");
        push(1, 1, 0, e_fetch(0), "rw_next_fetch");
        push(1, 1, 1, e_fetch(1), "mid_fetch");
        push(1, 1, 0, e_decode(), "mid_decode");
        push(1, 1, 0, e_memadr(1), "mid_memadr");
        push(1, 1, 0, E_MEMWR, "mid_memwrite");
        push(1, 0, 0, 20'h0, "mid_reset_drops_memwrite");
        push(1, 1, 0, e_fetch(0), "mid_after_reset");
        drain();
    endtask

`ifdef RISCV_MC_PERF_CNT_EN
    task automatic test_perf();
        instr(7'b0010011, 3'b000, 1'b0);
        push(0, 0, 0, 20'h0, "perf_reset");
        for (int i = 0; i < 5; i++) begin
            push_front_end(0, 0, "perf_addi");
            push(0, 1, 0, e_execi(4'h0), "perf_addi_execi");
            push(0, 1, 0, e_aluwb(), "perf_addi_aluwb");
        end
        push(0, 1, 0, e_fetch(0), "perf_fetch");
        drain();
        total++;
        if (ret_a !== 4'd5) begin bad++; $display("FAIL perf_instret: got %0d want 5", ret_a); end
        total++;
        if (cyc_a !== 4'd4) begin bad++; $display("FAIL perf_cycle20: got %0d want 4", cyc_a); end
        for (int i = 0; i < 11; i++) push(0, 1, 0, e_fetch(0), "perf_stall");
        drain();
        total++;
        if (cyc_a !== 4'd15) begin bad++; $display("FAIL perf_cycle15: got %0d want 15", cyc_a); end
        push(0, 1, 0, e_fetch(0), "perf_stall_wrap");
        drain();
        total++;
        if (cyc_a !== 4'd0) begin bad++; $display("FAIL perf_wrap: got %0d want 0", cyc_a); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;
        zf = 1'b0; nf = 1'b0; vf = 1'b0; cf = 1'b0;
        #1 reset = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_jump_upper();
        test_illegal();
        test_timeout();
`ifdef RISCV_MC_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
